// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: a DEPTH-entry {pc, instr} FIFO with a single outstanding memory read.
// Optional statistics counters are enabled by defining FETCH_STATS_EN.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] empty_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             inflight_q, inflight_d;
  logic             discard_q, discard_d;

  logic ack_fire;
  logic wr_en;
  logic pop;

  assign valid   = (count_q != '0);
  assign instr   = valid ? instr_mem_q[rd_ptr_q] : '0;
  assign pc      = valid ? pc_mem_q[rd_ptr_q] : '0;
  assign pcplus4 = valid ? pc_mem_q[rd_ptr_q] + 32'd4 : '0;

  // An in-flight read holds its address; a new one issues only when its slot is guaranteed.
  assign mem_req  = ~reset & (inflight_q | (count_q < DEPTH_C));
  assign mem_addr = inflight_q ? req_addr_q : fetch_pc_q;

  assign ack_fire = mem_req & mem_ack;
  assign wr_en    = ack_fire & ~discard_q & ~redirect;
  assign pop      = deq & valid & ~redirect;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    inflight_d = mem_req & ~mem_ack;
    req_addr_d = mem_addr;

    if (wr_en) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      fetch_pc_d = mem_addr + 32'd4;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (ack_fire) begin
      discard_d = 1'b0;
    end

    // A redirect flushes everything; a read still outstanding afterwards returns stale data.
    if (redirect) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      discard_d  = mem_req & ~mem_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem_q[wr_ptr_q]    <= mem_addr;
      instr_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] empty_cycles_q, empty_cycles_d;

  always_comb begin
    fetch_count_d  = fetch_count_q + {31'b0, wr_en};
    empty_cycles_d = empty_cycles_q + {31'b0, ~valid};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q  <= '0;
      empty_cycles_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      empty_cycles_q <= empty_cycles_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign empty_cycles = empty_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized self-checking bench for fetch_buffer against a queue-based reference model.
// Counter outputs are also checked when FETCH_STATS_EN is defined.
module tb_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam logic [31:0] KEY      = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] empty_cycles;
`endif

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq         (deq),
    .valid       (valid),
    .instr       (instr),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count (fetch_count),
    .empty_cycles(empty_cycles)
`endif
  );

  // Reference model: buffered entries in fetch order plus the fetch-side bookkeeping.
  logic [31:0] m_pc    [$];
  logic [31:0] m_instr [$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_addr;
  bit          m_inflight;
  bit          m_discard;
  bit          m_known;
  int unsigned m_fetch_cnt;
  int unsigned m_empty_cnt;
  int          wait_cnt;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic run_cycle(input bit rst, input bit redir, input logic [31:0] rpc,
                           input bit dq, input int lat, input bit spurious);
    bit          exp_valid;
    bit          exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    bit          ack;
    bit          fire;
    bit          wr;
    bit          pp;

    @(negedge clk);
    reset       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    deq         = dq;
    #1;
    exp_valid = (m_pc.size() > 0);
    exp_pc    = exp_valid ? m_pc[0] : 32'h0;
    exp_instr = exp_valid ? m_instr[0] : 32'h0;
    exp_pc4   = exp_valid ? m_pc[0] + 32'd4 : 32'h0;
    exp_req   = !rst && (m_inflight || (m_pc.size() < DEPTH));
    exp_addr  = m_inflight ? m_req_addr : m_fetch_pc;
    if (m_known) begin
      check("valid",    {31'b0, valid},   {31'b0, exp_valid});
      check("pc",       pc,               exp_pc);
      check("instr",    instr,            exp_instr);
      check("pcplus4",  pcplus4,          exp_pc4);
      check("mem_req",  {31'b0, mem_req}, {31'b0, exp_req});
      check("mem_addr", mem_addr,         exp_addr);
`ifdef FETCH_STATS_EN
      check("fetch_count",  fetch_count,  m_fetch_cnt);
      check("empty_cycles", empty_cycles, m_empty_cnt);
`endif
    end

    // Memory responder: ack a held request after lat waiting cycles.
    if (mem_req === 1'b1) begin
      if (wait_cnt >= lat) begin
        ack      = 1'b1;
        wait_cnt = 0;
      end else begin
        ack      = 1'b0;
        wait_cnt++;
      end
    end else begin
      ack      = spurious && ($urandom_range(3) == 0);
      wait_cnt = 0;
    end
    mem_ack   = ack;
    mem_rdata = mem_addr ^ KEY;

    @(posedge clk);
    if (rst) begin
      m_pc.delete();
      m_instr.delete();
      m_fetch_pc  = RESET_PC;
      m_req_addr  = RESET_PC;
      m_inflight  = 1'b0;
      m_discard   = 1'b0;
      m_fetch_cnt = 0;
      m_empty_cnt = 0;
      m_known     = 1'b1;
    end else if (m_known) begin
      if (!exp_valid) m_empty_cnt++;
      fire = exp_req && ack;
      wr   = fire && !m_discard && !redir;
      pp   = dq && exp_valid && !redir;
      if (pp) begin
        void'(m_pc.pop_front());
        void'(m_instr.pop_front());
      end
      if (wr) begin
        m_pc.push_back(exp_addr);
        m_instr.push_back(exp_addr ^ KEY);
        m_fetch_pc = exp_addr + 32'd4;
        m_fetch_cnt++;
      end
      if (redir) begin
        m_pc.delete();
        m_instr.delete();
        m_fetch_pc = rpc;
        m_discard  = exp_req && !ack;
      end else if (fire) begin
        m_discard = 1'b0;
      end
      m_inflight = exp_req && !ack;
      m_req_addr = exp_addr;
    end
  endtask

  initial begin
    logic [31:0] target;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    deq         = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    m_known     = 1'b0;
    m_inflight  = 1'b0;
    m_discard   = 1'b0;
    m_fetch_pc  = RESET_PC;
    m_req_addr  = RESET_PC;
    m_fetch_cnt = 0;
    m_empty_cnt = 0;
    wait_cnt    = 0;
    n_checks    = 0;
    n_errors    = 0;

    // Zero-wait streaming with continuous dequeue.
    repeat (3) run_cycle(1, 0, 32'h0, 0, 0, 0);
    repeat (20) run_cycle(0, 0, 32'h0, 1, 0, 0);

    // Fill to full with no dequeue, pop once, stay stalled.
    run_cycle(1, 0, 32'h0, 0, 0, 0);
    repeat (10) run_cycle(0, 0, 32'h0, 0, 0, 0);
    run_cycle(0, 0, 32'h0, 1, 0, 0);
    repeat (5) run_cycle(0, 0, 32'h0, 0, 0, 0);

    // Two-cycle memory latency with random dequeue.
    run_cycle(1, 0, 32'h0, 0, 0, 0);
    repeat (40) run_cycle(0, 0, 32'h0, 1'($urandom_range(1)), 2, 0);

    // Redirect to 0x400 while the read of 0x8 is held for three cycles.
    run_cycle(1, 0, 32'h0, 0, 0, 0);
    repeat (2) run_cycle(0, 0, 32'h0, 0, 0, 0);
    run_cycle(0, 0, 32'h0, 0, 3, 0);
    run_cycle(0, 1, 32'h400, 0, 3, 0);
    repeat (15) run_cycle(0, 0, 32'h0, 1, 3, 0);

    // Address wrap at 2^32.
    run_cycle(0, 1, 32'hFFFFFFF8, 1, 0, 0);
    repeat (8) run_cycle(0, 0, 32'h0, 1, 0, 0);

    // Randomized traffic: redirects, resets mid-handshake, stray acks, variable latency.
    repeat (3000) begin
      target = $urandom() & 32'hFFFFFFFC;
      if ($urandom_range(7) == 0) target = 32'hFFFFFFFC;
      run_cycle($urandom_range(63) == 0, $urandom_range(7) == 0, target,
                1'($urandom_range(1)), $urandom_range(3), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, sets the buffer entry count; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h00000000, sets the first fetch address after reset.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect  input  1  taken branch or jump; flush the buffer and refetch.
REQ-006 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-007 deq  input  1  decode consumes the head entry (driven by ~stallD).
REQ-008 valid  output  1  head entry present.
REQ-009 instr  output  32  head instruction.
REQ-010 pc  output  32  head instruction address.
REQ-011 pcplus4  output  32  pc+4 modulo 2^32.
REQ-012 mem_req  output  1  instruction memory read request.
REQ-013 mem_addr  output  32  request address.
REQ-014 mem_ack  input  1  read complete; mem_rdata valid this cycle.
REQ-015 mem_rdata  input  32  read data.

Function
REQ-016 The buffer SHALL be a DEPTH-entry FIFO of {pc, instr}; the head drives instr, pc and pcplus4 registered, with no combinational path from any input.
REQ-017 At most one request SHALL be in flight; once raised, mem_req and mem_addr SHALL hold stable until the edge where mem_ack=1.
REQ-018 A new request SHALL issue only if occupancy + in-flight < DEPTH; mem_req MAY stay high back-to-back across acks.
REQ-019 On an ack not discarded, {mem_addr, mem_rdata} SHALL be written at the tail and the fetch address SHALL advance by 4, wrapping at 2^32.
REQ-020 With zero-wait memory (ack in the same cycle as req), an entry SHALL become valid one cycle after the ack edge.
REQ-021 deq with valid=1 SHALL pop the head; deq with valid=0 SHALL be ignored.
REQ-022 Simultaneous write and pop SHALL keep occupancy unchanged, including when full or when going from empty through one entry.
REQ-023 On redirect, the next cycle SHALL show valid=0, the FIFO SHALL be empty, and the fetch address SHALL equal redirect_pc.
REQ-024 Redirect SHALL take priority over deq and over an ack in the same cycle; that ack's data SHALL be discarded.
REQ-025 On redirect while a request is pending without ack:
- mem_req/mem_addr SHALL hold until the ack;
- the ack's data SHALL be discarded;
- the request for redirect_pc SHALL issue the cycle after that ack.
REQ-026 A second redirect before the pending ack SHALL overwrite the target; only the last redirect_pc SHALL be fetched.

Reset
REQ-027 reset=1 SHALL produce at the next edge: valid=0, mem_req=0, mem_addr=RESET_PC, FIFO empty, no discard pending; instr, pc and pcplus4 SHALL read 0.
REQ-028 reset mid-handshake SHALL abandon the request; a later ack for it SHALL be ignored while mem_req=0.
REQ-029 The first mem_req SHALL assert in the first cycle after reset deasserts, with mem_addr=RESET_PC.

Configuration
REQ-030 With macro FETCH_STATS_EN defined:
- output fetch_count (32) SHALL count entries written;
- output empty_cycles (32) SHALL count cycles with valid=0 and reset=0;
- both SHALL wrap at 2^32 and reset to 0.
REQ-031 Without FETCH_STATS_EN, those ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-032 Reset, zero-wait memory returning rdata=addr^32'hFFFF0000, deq=1 -> mem_addr 0,4,8 on consecutive cycles; first valid shows pc=0, pcplus4=4, instr=32'hFFFF0000.
REQ-033 deq=0, zero-wait ack -> exactly 4 entries written (pc 0x0..0xC), mem_req low while full; a single deq re-raises mem_req with addr 0x10.
REQ-034 2-cycle ack latency -> mem_req and mem_addr stable over the wait; entries are in order with no duplicates.
REQ-035 Pending request to 0x8 delayed 3 cycles, redirect to 0x400 -> valid=0; 0x8 data never appears; next mem_addr=0x400; head pc=0x400.
REQ-036 Full buffer, redirect+deq+ack in the same cycle -> valid=0 next cycle; occupancy 0; no entry from that ack.
REQ-037 FETCH_STATS_EN build, 10 zero-wait fetches with deq=1 -> fetch_count=10; empty_cycles equals the number of cycles valid was low.
